env_table_loader: RTL
=====================

# env_table_loader

Runtime writer for the envelope lookup table. Accepts a framed byte stream over a valid/ready handshake, assembles `PCM_QUANT`-bit envelope words, and stores them in an internal table RAM. The RAM read port is what the envelope player indexes, so envelope shapes change without resynthesis. Sits between the host/UART byte interface and the envelope player.

## Interface
- `DEPTH`, default `3*ENVELOPE_FREQ`: table entries; max loadable word count.
- `AW`, default `16`: address width; `DEPTH <= 2**AW`.
- `clk  in  1`: system clock. Also drives the read port.
- `clr  in  1`: reset, asynchronous and active-high.
- `in_data  in  8`: stream byte.
- `in_valid  in  1`: byte present.
- `in_ready  out  1`: loader accepts byte. Transfer occurs when valid && ready.
- `raddr  in  AW`: player read address.
- `rdata  out  PCM_QUANT`: table word, registered, 1-cycle latency.
- `len  out  AW`: committed valid word count. The player clamps its index to `len-1`.
- `busy  out  1`: frame in progress (state not IDLE).
- `done  out  1`: 1-cycle pulse, frame committed.
- `err  out  1`: 1-cycle pulse, frame rejected.

## Operation
- Frame format: `0xA5` sync, `LEN_HI`, `LEN_LO`, then N words of 2 bytes each (MSB first; low `PCM_QUANT` bits kept, `PCM_QUANT <= 16`), then an optional checksum byte (see Configuration).
- Word k is written to address k.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, COMMIT.
  - IDLE: bytes other than `0xA5` are dropped. Sync moves to LEN_HI.
  - LEN_HI → LEN_LO.
  - LEN_LO: N = {hi, lo}. If N == 0 or N > DEPTH: `err`, go to IDLE. Otherwise go to DATA_HI.
  - DATA_HI latches the high byte. DATA_LO writes the RAM and increments the word counter.
  - After word N-1: go to CSUM if checksum is enabled, else COMMIT.
  - CSUM: on match go to COMMIT; on mismatch `err`, IDLE.
  - COMMIT (1 cycle): `len <= N`, `done` pulse, IDLE.
- `len` changes only in COMMIT. A rejected frame leaves `len` at its previous value. RAM words already written by the rejected frame stay overwritten.
- RAM: one write port (loader) and one read port (player), both on `clk`. Reading an address in the same cycle it is written returns the old data.

## Timing
- Reset values: `in_ready=0` during reset and `1` after, state IDLE, `len=0`, `busy=0`, `done=0`, `err=0`, `rdata=0`. RAM contents are undefined after reset.
- `in_ready` is 1 in every state except COMMIT, where it is 0 for exactly one cycle.
- Each byte takes one cycle. A back-to-back frame of N words completes with `done` at cycle 3+2N(+1)+1 after the sync byte is accepted.
- `busy` rises the cycle after sync is accepted and falls the same cycle `done` or `err` pulses.
- `done` and `err` are never high together.
- Reset mid-frame: immediate return to IDLE, `len=0`, no pulse.
- `in_valid` low stalls the FSM indefinitely, with no timeout.

## Configuration
- `ENV_LOADER_CHECKSUM_EN` defined:
  - Frame ends with a checksum byte equal to the XOR of every byte after sync (LEN_HI through the last data byte).
  - CSUM state exists and a mismatch yields `err`.
- Not defined:
  - No checksum byte. The FSM goes DATA_LO → COMMIT after the last word.
  - The CSUM state and the XOR accumulator are absent.

## Structure
- `def.v` holds:
  - `ENV_SYNC_BYTE` (`8'hA5`).
  - State encodings.
  - `ENVELOPE_FREQ`, with the default `DEPTH` derived from it.
- Sub-module `env_table_ram`: simple dual-port RAM, `PCM_QUANT` × `DEPTH`, registered read. The FSM and word assembler stay in `env_table_loader`.

## Test plan
- Bytes `A5 00 02 12 34 56 78` (plus checksum `0x0A` if enabled) → RAM[0]=`0x1234`, RAM[1]=`0x5678` (masked to `PCM_QUANT`), `done` pulse, `len=2`, `busy` low.
- Garbage `00 FF 13` then a valid 1-word frame → garbage ignored, frame commits, `len=1`.
- Length field `00 00` or `DEPTH+1` → `err` pulse right after LEN_LO, `len` keeps its prior value, the next sync is accepted.
- Checksum build: valid frame with the last byte corrupted → `err`, `len` unchanged, no `done`.
- `clr` asserted halfway through the data bytes → `busy=0`, `len=0`, no pulse; a following full frame loads correctly.
- `in_valid` toggled randomly, with `raddr` sweeping during the load → data identical to the back-to-back case; `rdata` follows `raddr` with 1-cycle latency; `in_ready` low only in COMMIT.

Source files
------------

// File: rtl/env_table_loader_pkg.sv
// env_table_loader_pkg
// Shared definitions for the envelope table loader: the frame sync byte, the
// envelope sample rate the default table depth is derived from, the PCM word
// width, the loader FSM state encoding and the word-assembly helper.
// Optional feature macro used by the loader: ENV_LOADER_CHECKSUM_EN.
package env_table_loader_pkg;

    localparam logic [7:0] ENV_SYNC_BYTE     = 8'hA5;
    localparam int         ENVELOPE_FREQ     = 16;
    localparam int         ENV_DEPTH_DEFAULT = 3 * ENVELOPE_FREQ;
    localparam int         PCM_QUANT         = 12;   // must be <= 16

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CSUM    = 3'd5,
        ST_COMMIT  = 3'd6
    } state_e;

    // Two stream bytes (MSB first) -> one table word; only the low PCM_QUANT
    // bits are kept.
    function automatic logic [PCM_QUANT-1:0] pcm_word(input logic [7:0] hi,
                                                      input logic [7:0] lo);
        return PCM_QUANT'({hi, lo});
    endfunction

endpackage

// File: rtl/env_table_loader_ram.sv
// env_table_ram
// Simple dual-port table RAM: one write port (loader) and one registered read
// port (envelope player), both on clk. A read of the address being written in
// the same cycle returns the old word. Out-of-range reads return 0 and
// out-of-range writes are ignored.
// Ports:
//   clk, clr        clock, async active-high reset (read register only)
//   we/waddr/wdata  write port
//   raddr/rdata     read port, 1-cycle latency
module env_table_ram #(
    parameter int W     = 12,
    parameter int DEPTH = 48,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q, rdata_d;
    logic         rd_ok, wr_ok;

    assign rd_ok = 32'(raddr) < DEPTH_U;
    assign wr_ok = 32'(waddr) < DEPTH_U;

    always_comb begin
        rdata_d = '0;
        if (rd_ok) begin
            rdata_d = mem[raddr[IW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (we && wr_ok) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/env_table_loader.sv
// env_table_loader
// Runtime writer for the envelope lookup table. Parses a framed byte stream
// (sync 0xA5, LEN_HI, LEN_LO, N big-endian 16-bit words, optional checksum)
// arriving over valid/ready, writes word k to table address k and commits
// the word count to len once the whole frame is accepted.
// Build option: define ENV_LOADER_CHECKSUM_EN to require a trailing checksum
// byte (XOR of every byte after sync); without it the frame ends after the
// last data word.
// Ports:
//   clk, clr            clock, async active-high reset
//   in_data/in_valid    stream byte and its valid
//   in_ready            byte accepted when in_valid && in_ready
//   raddr/rdata         player read port, rdata registered (1-cycle latency)
//   len                 committed word count
//   busy                frame in progress
//   done/err            1-cycle pulses: frame committed / frame rejected
module env_table_loader
    import env_table_loader_pkg::*;
#(
    parameter int DEPTH = ENV_DEPTH_DEFAULT,
    parameter int AW    = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AW-1:0]        raddr,
    output logic [PCM_QUANT-1:0] rdata,
    output logic [AW-1:0]        len,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    state_e        state_q, state_d;
    logic [7:0]    hi_q, hi_d;        // LEN_HI byte, then each word's high byte
    logic [AW-1:0] n_q, n_d;          // word count of the frame in flight
    logic [AW-1:0] cnt_q, cnt_d;      // next word address
    logic [AW-1:0] len_q, len_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          ready_q, ready_d;
`ifdef ENV_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    logic                 accept;
    logic                 we;
    logic [15:0]          n16;
    logic                 len_bad;
    logic [PCM_QUANT-1:0] wdata;

    assign accept  = in_valid && ready_q;
    assign n16     = {hi_q, in_data};
    assign len_bad = (n16 == 16'd0) || ({16'd0, n16} > DEPTH_U);
    assign wdata   = pcm_word(hi_q, in_data);

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        we      = 1'b0;
`ifdef ENV_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        // Running XOR over LEN_HI .. last data byte; cleared while idle.
        if (state_q == ST_IDLE) begin
            csum_d = 8'h00;
        end else if (accept && (state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO})) begin
            csum_d = csum_q ^ in_data;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept && (in_data == ENV_SYNC_BYTE)) begin
                    cnt_d   = '0;
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    if (len_bad) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        n_d     = AW'(n16);
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (accept) begin
                    we    = 1'b1;
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == n_q - AW'(1)) begin
`ifdef ENV_LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_COMMIT;
`endif
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_CSUM: begin
`ifdef ENV_LOADER_CHECKSUM_EN
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = ST_COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_COMMIT: begin
                len_d   = n_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The only non-accepting cycle is COMMIT, so ready is known one state ahead.
    assign ready_d = (state_d != ST_COMMIT);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
`ifdef ENV_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
`ifdef ENV_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    env_table_ram #(
        .W     (PCM_QUANT),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .clr   (clr),
        .we    (we),
        .waddr (cnt_q),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign in_ready = ready_q;
    assign len      = len_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign err      = err_q;

endmodule
